system_bus_sequencer: RTL and testbench
=======================================

Name: system_bus_sequencer

Overview:
- Registered, multi-cycle successor to the CPU's combinational system bus driver.
- Arbitrates three CPU bus requesters: interrupt vector fetch, instruction/index-offset fetch, and operand read/write.
- Drives MAB/MDBout/BW/MW for 1+WAIT_STATES cycles per access, captures read data, and returns a one-cycle acknowledge.
- Sits between the CPU control unit and the memory/peripheral bus.

Parameters:
- ADDR_W, 16, width of all address buses.
- DATA_W, 16, data bus width. Must be even and at least 16; the byte lane is bits [7:0].
- WAIT_STATES, 0, extra ACCESS cycles per transaction, range 0..15.

Ports:
- MCLK  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_vec  in  1  interrupt vector fetch request; level, held until ack.
- vec_addr  in  ADDR_W  IVT entry address.
- req_fetch  in  1  instruction or index-offset fetch request.
- pc  in  ADDR_W  program counter.
- req_data  in  1  operand access request.
- data_we  in  1  1 = write, 0 = read.
- data_byte  in  1  1 = byte access (IW bit 6), 0 = word access.
- data_addr  in  ADDR_W  operand address.
- data_wr  in  DATA_W  write data (function-unit result).
- MDBin  in  DATA_W  memory data bus input.
- MAB  out  ADDR_W  memory address bus.
- MDBout  out  DATA_W  memory write data.
- BW  out  1  byte access qualifier.
- MW  out  1  memory write enable.
- grant  out  2  active channel: 0 none, 1 vec, 2 fetch, 3 data.
- ack  out  1  one-cycle completion pulse.
- rdata  out  DATA_W  captured read data; valid while ack=1, held until the next capture.
- busy  out  1  high in ACCESS.
- fault  out  1  alignment fault pulse (optional feature only).

Behaviour:
- Reset: state=IDLE; MAB=0, MDBout=0, BW=0, MW=0, grant=0, ack=0, rdata=0, busy=0, fault=0.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - Samples requests with fixed priority vec > fetch > data.
  - Latches address, data, attributes and channel, then moves to ACCESS.
  - With no request, stays in IDLE.
- ACCESS:
  - Bus outputs are driven from the latched registers only.
  - A wait counter loads WAIT_STATES on entry and decrements each cycle.
  - When the counter reaches 0, MDBin is sampled into rdata at that edge and the state moves to DONE.
  - ACCESS therefore lasts exactly 1+WAIT_STATES cycles.
- DONE:
  - ack=1 for exactly one cycle; grant keeps the completed channel.
  - The arbiter re-evaluates in this same cycle. A request other than the one just acknowledged goes directly to ACCESS; otherwise the state returns to IDLE.
  - The acknowledged requester deasserts on ack, so it is excluded in this cycle.
  - Throughput: one transaction per 2+WAIT_STATES cycles.
- Request first seen at edge N (WAIT_STATES=0): ACCESS in cycle N+1, ack in cycle N+2.
- Vec and fetch accesses: BW=0, MW=0, word read, MAB=address as given.
- Data word access: MAB={addr[ADDR_W-1:1],0}, BW=0.
- Data byte access: MAB=addr unmasked, BW=1.
- Writes:
  - MW=1 for every ACCESS cycle of a write.
  - MDBout = data_wr for word writes, and {0, data_wr[7:0]} for byte writes.
  - Writes do not update rdata.
- Reads: byte reads capture {0, MDBin[7:0]}; word reads capture the full MDBin.
- Outside ACCESS: MAB=0, MDBout=0, BW=0, MW=0.
- A request that drops before acceptance is ignored; no ack is issued.
- Request input changes during ACCESS have no effect, because all values were latched.
- Reset mid-ACCESS: IDLE on the next edge, MW deasserts, no ack, rdata cleared.
- Simultaneous requests: only the highest priority is granted. Lower requests are served in later transactions; no starvation guarantee is given for data.

Optional Feature:
- Macro: SYSTEM_BUS_ALIGN_FAULT_EN.
- Defined: a data word access with data_addr[0]=1 skips ACCESS entirely. IDLE goes to DONE with ack=1 and fault=1 for one cycle, rdata unchanged, and no bus cycle (MW stays 0).
- Undefined: the address LSB is masked as above, and fault is tied 0.

Decomposition:
- Shared PARAMS include holds the state encodings (IDLE, ACCESS, DONE) and the grant codes (GNT_NONE, GNT_VEC, GNT_FETCH, GNT_DATA).
- Sub-module system_bus_wait_counter: 4-bit loadable down-counter with load/en inputs and a zero flag. It is instantiated once.

Test Plan:
- WAIT_STATES=0, req_fetch=1, pc=16'h4400, MDBin=16'h4031 -> MAB=16'h4400 in cycle N+1, ack in N+2, rdata=16'h4031, grant=2.
- WAIT_STATES=2, req_data=1, data_we=1, data_byte=1, data_addr=16'h0201, data_wr=16'hABCD -> MAB=16'h0201, BW=1, MW=1 for 3 cycles, MDBout=16'h00CD, then ack.
- req_vec, req_fetch and req_data all asserted together -> grants in order 1, 2, 3. Each ack is one cycle and consecutive transactions are 2 cycles apart.
- Word read at data_addr=16'h0203, MDBin=16'h1234 -> macro off: MAB=16'h0202, rdata=16'h1234. Macro on: no ACCESS cycle, fault=1 with ack, MW=0.
- reset asserted during the second ACCESS cycle of a write with WAIT_STATES=3 -> next edge MW=0, MAB=0, no ack, state IDLE.
- Byte read at 16'h0300 with MDBin=16'hBEEF -> rdata=16'h00EF.

Source files
------------

// File: rtl/system_bus_sequencer_pkg.sv
// system_bus_sequencer_pkg
// Shared definitions for the system bus sequencer: FSM state encoding,
// grant channel codes and the fixed-priority arbiter helper.
package system_bus_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  localparam logic [1:0] GNT_NONE  = 2'd0;
  localparam logic [1:0] GNT_VEC   = 2'd1;
  localparam logic [1:0] GNT_FETCH = 2'd2;
  localparam logic [1:0] GNT_DATA  = 2'd3;

  // Fixed priority vec > fetch > data. 'excl' removes the channel that is
  // being acknowledged this cycle, since its request is still visible while
  // the requester reacts to ack.
  function automatic logic [1:0] arb_pick(input logic v, input logic f,
                                          input logic d, input logic [1:0] excl);
    if (v && excl != GNT_VEC)   return GNT_VEC;
    if (f && excl != GNT_FETCH) return GNT_FETCH;
    if (d && excl != GNT_DATA)  return GNT_DATA;
    return GNT_NONE;
  endfunction

endpackage

// File: rtl/system_bus_sequencer_if.sv
// system_bus_sequencer_if
// Groups the CPU requester signals and the memory bus of the sequencer.
//   slave  : sequencer view (requests + MDBin in, bus + ack/status out)
//   master : CPU/memory view (the opposite directions)
interface system_bus_sequencer_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              req_vec;
  logic [ADDR_W-1:0] vec_addr;
  logic              req_fetch;
  logic [ADDR_W-1:0] pc;
  logic              req_data;
  logic              data_we;
  logic              data_byte;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] data_wr;
  logic [DATA_W-1:0] MDBin;
  logic [ADDR_W-1:0] MAB;
  logic [DATA_W-1:0] MDBout;
  logic              BW;
  logic              MW;
  logic [1:0]        grant;
  logic              ack;
  logic [DATA_W-1:0] rdata;
  logic              busy;
  logic              fault;

  modport slave (
    input  req_vec, vec_addr, req_fetch, pc, req_data, data_we, data_byte,
           data_addr, data_wr, MDBin,
    output MAB, MDBout, BW, MW, grant, ack, rdata, busy, fault
  );

  modport master (
    output req_vec, vec_addr, req_fetch, pc, req_data, data_we, data_byte,
           data_addr, data_wr, MDBin,
    input  MAB, MDBout, BW, MW, grant, ack, rdata, busy, fault
  );
endinterface

// File: rtl/system_bus_wait_counter.sv
// system_bus_wait_counter
// 4-bit loadable down-counter that times the ACCESS phase.
//   i_clk, i_rst   : clock, synchronous active-high reset
//   i_load         : load i_load_val (has priority over i_en)
//   i_en           : decrement, saturating at 0
//   o_zero         : count is 0
module system_bus_wait_counter (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_load,
  input  logic       i_en,
  input  logic [3:0] i_load_val,
  output logic       o_zero
);
  logic [3:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst)                    r_cnt <= '0;
    else if (i_load)              r_cnt <= i_load_val;
    else if (i_en && r_cnt != '0) r_cnt <= r_cnt - 4'd1;
  end

  assign o_zero = (r_cnt == '0);
endmodule

// File: rtl/system_bus_sequencer.sv
// system_bus_sequencer
// Registered multi-cycle system bus sequencer. Arbitrates vector fetch,
// instruction fetch and operand access, drives MAB/MDBout/BW/MW for
// 1+WAIT_STATES cycles, captures read data and pulses ack for one cycle.
//   MCLK  : clock          reset : synchronous active-high reset
//   bus   : system_bus_sequencer_if.slave (requests, memory bus, status)
// Build option: SYSTEM_BUS_ALIGN_FAULT_EN -- odd-address data word accesses
// skip the bus cycle and complete with ack+fault instead of being masked.
module system_bus_sequencer
  import system_bus_sequencer_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int WAIT_STATES = 0
) (
  input  logic MCLK,
  input  logic reset,
  system_bus_sequencer_if.slave bus
);
  localparam logic [3:0] WS4 = 4'(WAIT_STATES);

  state_e            r_state, w_nxt;
  logic [1:0]        r_ch, w_sel;
  logic [ADDR_W-1:0] r_addr, w_addr;
  logic [DATA_W-1:0] r_wdat, w_wdat, r_rdata;
  logic              r_we, r_byte, r_fault;
  logic              w_we, w_byte, w_fault, w_take, w_load, w_acc, w_zero;

  assign w_acc = (r_state == ACCESS);

  always_comb begin
    w_sel   = arb_pick(bus.req_vec, bus.req_fetch, bus.req_data,
                       (r_state == DONE) ? r_ch : GNT_NONE);
    w_addr  = '0;
    w_wdat  = '0;
    w_we    = 1'b0;
    w_byte  = 1'b0;
    w_fault = 1'b0;
    case (w_sel)
      GNT_VEC:   w_addr = bus.vec_addr;
      GNT_FETCH: w_addr = bus.pc;
      GNT_DATA: begin
        w_we   = bus.data_we;
        w_byte = bus.data_byte;
        w_addr = bus.data_byte ? bus.data_addr : {bus.data_addr[ADDR_W-1:1], 1'b0};
        if (bus.data_we)
          w_wdat = bus.data_byte ? {{(DATA_W-8){1'b0}}, bus.data_wr[7:0]} : bus.data_wr;
`ifdef SYSTEM_BUS_ALIGN_FAULT_EN
        w_fault = !bus.data_byte && bus.data_addr[0];
`endif
      end
      default: ;
    endcase

    // New work is only accepted from IDLE or from DONE (back-to-back).
    w_take = (r_state != ACCESS) && (w_sel != GNT_NONE);
    w_load = w_take && !w_fault;

    w_nxt = r_state;
    case (r_state)
      IDLE, DONE: w_nxt = w_take ? (w_fault ? DONE : ACCESS) : IDLE;
      ACCESS:     if (w_zero) w_nxt = DONE;
      default:    w_nxt = IDLE;
    endcase
  end

  always_ff @(posedge MCLK) begin
    if (reset) begin
      r_state <= IDLE;
      r_ch    <= GNT_NONE;
      r_addr  <= '0;
      r_wdat  <= '0;
      r_we    <= 1'b0;
      r_byte  <= 1'b0;
      r_fault <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_state <= w_nxt;
      if (w_take) begin
        r_ch    <= w_sel;
        r_addr  <= w_addr;
        r_wdat  <= w_wdat;
        r_we    <= w_we;
        r_byte  <= w_byte;
        r_fault <= w_fault;
      end
      // Capture on the edge that ends the last ACCESS cycle.
      if (w_acc && w_zero && !r_we)
        r_rdata <= r_byte ? {{(DATA_W-8){1'b0}}, bus.MDBin[7:0]} : bus.MDBin;
    end
  end

  system_bus_wait_counter u_wait (
    .i_clk      (MCLK),
    .i_rst      (reset),
    .i_load     (w_load),
    .i_en       (w_acc),
    .i_load_val (WS4),
    .o_zero     (w_zero)
  );

  // Bus is quiet outside ACCESS; during ACCESS only latched values drive it.
  assign bus.MAB    = w_acc ? r_addr : '0;
  assign bus.MDBout = w_acc ? r_wdat : '0;
  assign bus.BW     = w_acc & r_byte;
  assign bus.MW     = w_acc & r_we;
  assign bus.grant  = (r_state == IDLE) ? GNT_NONE : r_ch;
  assign bus.ack    = (r_state == DONE);
  assign bus.rdata  = r_rdata;
  assign bus.busy   = w_acc;
  assign bus.fault  = (r_state == DONE) & r_fault;
endmodule

// File: tb/tb_system_bus_sequencer.sv
// tb_system_bus_sequencer
// Three sequencer instances (WAIT_STATES 0, 2, 3) share stimulus; 'sel'
// routes requests to one of them and muxes its outputs back. The expected
// bus timeline is derived from the transaction list of each request batch.
module tb_system_bus_sequencer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  sel = 2'd0;
  logic        req_vec = 0, req_fetch = 0, req_data = 0, data_we = 0, data_byte = 0;
  logic [15:0] vec_addr = 0, pc = 0, data_addr = 0, data_wr = 0, MDBin = 0;
  bit          rnd_md = 0;
  bit          rv, rf, rd;
  int          checks = 0, errors = 0;
  logic [15:0] exp_rd [3];

  logic [2:0][15:0] mab_k, out_k, rd_k;
  logic [2:0][1:0]  gnt_k;
  logic [2:0]       bw_k, mw_k, ack_k, busy_k, flt_k;
  logic [15:0]      o_mab, o_out, o_rd;
  logic [1:0]       o_gnt;
  logic             o_bw, o_mw, o_ack, o_busy, o_flt;

  always #5 clk = ~clk;

  for (genvar k = 0; k < 3; k++) begin : g_dut
    system_bus_sequencer_if #(.ADDR_W(16), .DATA_W(16)) bif ();
    system_bus_sequencer #(.ADDR_W(16), .DATA_W(16), .WAIT_STATES(k == 0 ? 0 : k + 1))
      u_dut (.MCLK(clk), .reset(rst), .bus(bif));
    assign bif.req_vec   = req_vec   && (sel == 2'(k));
    assign bif.req_fetch = req_fetch && (sel == 2'(k));
    assign bif.req_data  = req_data  && (sel == 2'(k));
    assign bif.vec_addr  = vec_addr;
    assign bif.pc        = pc;
    assign bif.data_we   = data_we;
    assign bif.data_byte = data_byte;
    assign bif.data_addr = data_addr;
    assign bif.data_wr   = data_wr;
    assign bif.MDBin     = MDBin;
    assign mab_k[k]  = bif.MAB;
    assign out_k[k]  = bif.MDBout;
    assign rd_k[k]   = bif.rdata;
    assign gnt_k[k]  = bif.grant;
    assign bw_k[k]   = bif.BW;
    assign mw_k[k]   = bif.MW;
    assign ack_k[k]  = bif.ack;
    assign busy_k[k] = bif.busy;
    assign flt_k[k]  = bif.fault;
  end

  always_comb begin
    o_mab = mab_k[sel]; o_out = out_k[sel]; o_rd = rd_k[sel]; o_gnt = gnt_k[sel];
    o_bw = bw_k[sel]; o_mw = mw_k[sel]; o_ack = ack_k[sel];
    o_busy = busy_k[sel]; o_flt = flt_k[sel];
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_ack"},  16'(o_ack),  16'd0);
    chk({tag, "_busy"}, 16'(o_busy), 16'd0);
    chk({tag, "_gnt"},  16'(o_gnt),  16'd0);
    chk({tag, "_mw"},   16'(o_mw),   16'd0);
    chk({tag, "_mab"},  o_mab,       16'd0);
    chk({tag, "_rd"},   o_rd,        exp_rd[sel]);
  endtask

  // Requests raised now are seen at the next edge; channels are served in
  // priority order, each taking 1+ws ACCESS cycles then one ack cycle.
  task automatic run_batch(input bit bv, input bit bf, input bit bd);
    int ws;
    int chs[$];
    logic [15:0] a_vec, a_pc, a_dat, w_dat, e_mab, e_out, md_last;
    bit we, by, e_bw, e_mw, flt, rdop;
    ws = (sel == 2'd0) ? 0 : int'(sel) + 1;
    a_vec = vec_addr; a_pc = pc; a_dat = data_addr; w_dat = data_wr;
    we = data_we; by = data_byte; md_last = MDBin;
    if (bv) chs.push_back(1);
    if (bf) chs.push_back(2);
    if (bd) chs.push_back(3);
    req_vec = bv; req_fetch = bf; req_data = bd;
    foreach (chs[i]) begin
      e_bw = 0; e_mw = 0; e_out = 16'h0; rdop = 1; flt = 0; e_mab = 16'h0;
      case (chs[i])
        1: e_mab = a_vec;
        2: e_mab = a_pc;
        default: begin
          e_mab = by ? a_dat : (a_dat & 16'hFFFE);
          e_bw = by; e_mw = we; rdop = !we;
          e_out = by ? {8'h00, w_dat[7:0]} : w_dat;
`ifdef SYSTEM_BUS_ALIGN_FAULT_EN
          flt = !by && a_dat[0];
`endif
        end
      endcase
      if (!flt) begin
        for (int c = 0; c <= ws; c++) begin
          tick();
          chk("acc_busy", 16'(o_busy), 16'd1);
          chk("acc_gnt",  16'(o_gnt),  16'(chs[i]));
          chk("acc_mab",  o_mab,       e_mab);
          chk("acc_bw",   16'(o_bw),   16'(e_bw));
          chk("acc_mw",   16'(o_mw),   16'(e_mw));
          chk("acc_ack",  16'(o_ack),  16'd0);
          if (e_mw) chk("acc_mdbout", o_out, e_out);
          // Latched values must not follow input changes mid-access.
          if (c == 0) begin
            if (chs[i] == 1) vec_addr = 16'($urandom);
            if (chs[i] == 2) pc = 16'($urandom);
            if (chs[i] == 3) begin
              data_addr = 16'($urandom); data_wr = 16'($urandom);
              data_we = 1'($urandom); data_byte = 1'($urandom);
            end
          end
          if (rnd_md) MDBin = 16'($urandom);
          md_last = MDBin;
        end
      end
      tick();
      chk("done_ack",   16'(o_ack),  16'd1);
      chk("done_gnt",   16'(o_gnt),  16'(chs[i]));
      chk("done_busy",  16'(o_busy), 16'd0);
      chk("done_mw",    16'(o_mw),   16'd0);
      chk("done_mab",   o_mab,       16'd0);
      chk("done_fault", 16'(o_flt),  16'(flt));
      if (!flt && rdop)
        exp_rd[sel] = (chs[i] == 3 && by) ? {8'h00, md_last[7:0]} : md_last;
      chk("done_rdata", o_rd, exp_rd[sel]);
      if (chs[i] == 1) req_vec = 0;
      if (chs[i] == 2) req_fetch = 0;
      if (chs[i] == 3) req_data = 0;
    end
    tick();
    chk_quiet("idle");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    exp_rd = '{16'h0, 16'h0, 16'h0};
    tick(); tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      sel = 2'(k); #1;
      chk_quiet("reset");
      chk("reset_flt", 16'(o_flt), 16'd0);
      chk("reset_out", o_out, 16'd0);
    end

    // Fetch, WAIT_STATES=0.
    sel = 2'd0; rnd_md = 0; pc = 16'h4400; MDBin = 16'h4031;
    run_batch(0, 1, 0);
    chk("tp_fetch_rdata", o_rd, 16'h4031);

    // Byte write, WAIT_STATES=2.
    sel = 2'd1; data_we = 1; data_byte = 1; data_addr = 16'h0201; data_wr = 16'hABCD;
    run_batch(0, 0, 1);

    // All three requests at once.
    sel = 2'd0; vec_addr = 16'hFFFE; pc = 16'h4402; data_we = 0; data_byte = 0;
    data_addr = 16'h0300; MDBin = 16'h5555;
    run_batch(1, 1, 1);

    // Odd word read: masked, or faulted when the alignment option is built in.
    data_we = 0; data_byte = 0; data_addr = 16'h0203; MDBin = 16'h1234;
    run_batch(0, 0, 1);
`ifndef SYSTEM_BUS_ALIGN_FAULT_EN
    chk("tp_odd_rdata", o_rd, 16'h1234);
`endif

    // Byte read on the WAIT_STATES=3 instance.
    sel = 2'd2; data_byte = 1; data_addr = 16'h0300; MDBin = 16'hBEEF;
    run_batch(0, 0, 1);
    chk("tp_byte_rdata", o_rd, 16'h00EF);

    // Request pulse between edges is never accepted.
    sel = 2'd0; #1 req_fetch = 1; #2 req_fetch = 0;
    tick(); chk_quiet("pulse1");
    tick(); chk_quiet("pulse2");

    // Reset during the second ACCESS cycle of a write (WAIT_STATES=3).
    sel = 2'd2; data_we = 1; data_byte = 0; data_addr = 16'h0410; data_wr = 16'h5A5A;
    req_data = 1;
    tick(); chk("rst_acc1_mw", 16'(o_mw), 16'd1);
    tick(); chk("rst_acc2_mw", 16'(o_mw), 16'd1);
    rst = 1;
    tick();
    exp_rd = '{16'h0, 16'h0, 16'h0};
    chk_quiet("rst_mid");
    rst = 0; req_data = 0;
    tick(); chk_quiet("rst_after");
    tick(); chk_quiet("rst_after2");

    // Randomized batches across all three instances.
    rnd_md = 1;
    for (int it = 0; it < 60; it++) begin
      sel = 2'($urandom_range(0, 2));
      vec_addr = 16'($urandom); pc = 16'($urandom); data_addr = 16'($urandom);
      data_wr = 16'($urandom); data_we = 1'($urandom); data_byte = 1'($urandom);
      MDBin = 16'($urandom);
      do begin
        rv = 1'($urandom); rf = 1'($urandom); rd = 1'($urandom);
      end while (!(rv | rf | rd));
      run_batch(rv, rf, rd);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
